credit_rx: RTL
==============

Name: credit_rx

Overview:
- Receiving end of a credit-flow link. It sits downstream of a valid-only pipeline output (data plus valid, no accept), such as a multi-stage stall pipeline.
- Buffers arriving words in a DEPTH-entry store and presents them on a valid/accept interface to the consumer.
- Returns one credit pulse to the transmitter per freed entry, so the transmitter never overruns the store.
- On reset exit it advertises DEPTH initial credits.

Parameters:
- DEPTH, 4, number of buffer entries and of initial credits; legal range 2..64, any value (not restricted to powers of two).
- W, 32, data word width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- in  in  W  arriving data word.
- in_vld  in  1  push strobe; the word is transferred unconditionally (no accept).
- credit_ret_r  out  1  one-cycle credit pulse; each pulse grants the transmitter one more push.
- out_r  out  W  head-of-buffer data.
- out_vld_r  out  1  buffer non-empty.
- out_accept  in  1  consumer takes the head word when out_vld_r=1.
- overflow_r  out  1  sticky error: a push arrived with no free entry.

Behaviour:
- Reset (rst=0 at an edge):
  - pointers=0, count=0, state=INIT, init counter=0.
  - credit_ret_r=0, out_vld_r=0, out_r=0, overflow_r=0.
  - Storage contents are don't-care.
- States:
  - INIT: credit_ret_r=1 on each of DEPTH consecutive cycles starting the first cycle after rst deasserts. The init counter runs 0..DEPTH-1; after the DEPTH-th pulse the block moves to RUN.
  - RUN: terminal until reset.
- Push and pop are honoured in both states.
- Pop = out_vld_r & out_accept. The head advances, count decrements, and credit_ret_r=1 on the next cycle.
- In INIT the buffer is empty until the first push arrives. A pop during INIT returns a credit in addition to the init pulse.
  - Both are required; hold a pending-credit counter so no credit is lost (at most one pulse per cycle).
  - Counter width: clog2(DEPTH+1).
- Push = in_vld.
  - Accepted if count<DEPTH, or if count==DEPTH and a pop happens in the same cycle.
  - Otherwise the word is dropped, state is unchanged, and overflow_r is set and held until reset.
- Latency: push into an empty buffer at edge t gives out_vld_r=1 and out_r=in from cycle t+1 (one cycle). No same-cycle bypass.
- out_r is driven from the registered head entry and is stable while out_vld_r=1 and out_accept=0.
- Simultaneous push and pop: count is unchanged, both pointers advance, and order is preserved (FIFO).
- Pointer wrap: a pointer advancing from DEPTH-1 goes to 0 (explicit compare, not modulo).
- Count width is clog2(DEPTH+1); count never exceeds DEPTH.
- Credit conservation: initial credits + returned credits − accepted pushes always equals DEPTH − count (before overflow).
- Reset mid-operation discards buffered words and re-enters INIT with DEPTH fresh credits. The transmitter shares the same reset and zeroes its credit count.
- out_accept with out_vld_r=0 is ignored.

Decomposition:
- Shared package credit_rx_pkg holds:
  - the state enum {INIT, RUN};
  - a localparam function returning clog2(DEPTH+1) for count and credit widths.
- One sub-module, credit_rx_store: a DEPTH×W circular store with push/pop, head output, count, and full/empty flags.
- The top level holds the INIT/RUN FSM, the pending-credit counter and the overflow flag.

Test Plan:
1. Reset release, DEPTH=4, no traffic -> credit_ret_r high exactly cycles 1-4 after release, then 0. out_vld_r=0 and overflow_r=0 throughout.
2. Push 0xA5A5_0001 in one cycle with out_accept=1 -> out_vld_r=1 and out_r=0xA5A5_0001 the next cycle; popped that cycle. credit_ret_r=1 on the cycle after the pop.
3. out_accept=0, push 0x1,0x2,0x3,0x4 -> count=4 and out_r=0x1 held. Then out_accept=1 for 4 cycles -> out_r 0x1,0x2,0x3,0x4 in order, 4 credit pulses, out_vld_r=0 after.
4. Full buffer (4 words), push 0x5 without a pop -> 0x5 dropped, overflow_r=1 sticky, later drain yields 0x1-0x4 only. Repeat with a same-cycle pop -> 0x5 accepted and overflow_r stays 0.
5. Continuous push and pop every cycle for 20 words 0x0..0x13 -> output sequence identical, pointers wrap multiple times, count stays 1, one credit pulse per pop.
6. Assert rst=0 mid-stream with 3 words buffered -> next cycle out_vld_r=0 and count=0. After release, 4 fresh init credits are issued and the old words never appear.

Source files
------------

// File: rtl/credit_rx_pkg.sv
// rtl/credit_rx_pkg.sv - shared types and width helper for the credit receiver
// Contents:
//   state_t     : INIT (advertising initial credits) / RUN (steady state)
//   cnt_width() : bits needed to hold 0..depth inclusive
package credit_rx_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/credit_rx_store.sv
// rtl/credit_rx_store.sv - DEPTH x W circular word store with head output
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   push, wdata    : write wdata at the tail (caller guarantees room)
//   pop            : drop the head entry (caller guarantees non-empty)
//   rdata          : head entry, zero while empty
//   count          : number of stored words, 0..DEPTH
//   full, empty    : count==DEPTH / count==0
module credit_rx_store
  import credit_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[head];

endmodule

// File: rtl/credit_rx.sv
// rtl/credit_rx.sv - credit-flow link receiver: buffer, credit return, overflow flag
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   in, in_vld        : arriving word, pushed unconditionally when in_vld
//   credit_ret_r      : one-cycle pulse per credit granted to the transmitter
//   out_r, out_vld_r  : head word and buffer non-empty
//   out_accept        : consumer takes head when out_vld_r
//   overflow_r        : sticky, a push arrived with no free entry
module credit_rx
  import credit_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  input  logic         in_vld,
  output logic         credit_ret_r,
  output logic [W-1:0] out_r,
  output logic         out_vld_r,
  input  logic         out_accept,
  output logic         overflow_r
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  state_t        state;
  logic [CW-1:0] init_cnt;
  logic [CW-1:0] pending;

  assign out_vld_r = !empty;
  assign pop       = out_vld_r & out_accept;
  // A full store still takes a word when the head leaves in the same cycle.
  assign push_ok   = in_vld & ((count < CW'(DEPTH)) | pop);

  credit_rx_store #(.DEPTH(DEPTH), .W(W)) u_store (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata (in),
    .pop   (pop),
    .rdata (out_r),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      pending      <= '0;
      credit_ret_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (in_vld && full && !pop) overflow_r <= 1'b1;

      if (state == ST_INIT) begin
        // The pulse line is busy with init credits; park pop credits.
        credit_ret_r <= 1'b1;
        if (pop) pending <= pending + 1'b1;
        if (init_cnt == CW'(DEPTH - 1)) state <= ST_RUN;
        else                            init_cnt <= init_cnt + 1'b1;
      end else begin
        // One pulse per cycle: a fresh pop replaces the one being drained,
        // so pending only shrinks when no pop arrives.
        credit_ret_r <= pop || (pending != '0);
        if (pending != '0 && !pop) pending <= pending - 1'b1;
      end
    end
  end

endmodule
